decode_stage: RTL and testbench

Registered, elastic RV32I decode stage that sits between the fetch and execute stages. It accepts an instruction and PC through a valid/ready handshake and produces a registered control bundle, register indices and a sign-extended immediate. It is the pipelined, parametrised successor of the combinational decoder. It adds:
- a 2-entry skid buffer,
- flush,
- illegal-instruction detection,
- optional M-extension decode,
- a decoded-instruction counter.

---
 rtl/decode_pkg.sv | 72 +++++++
 rtl/decode_comb.sv | 140 ++++++++++++++
 rtl/decode_stage.sv | 148 ++++++++++++++
 tb/tb_decode_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I decode stage: ALU codes, operand/writeback selects,
// opcodes and the packed control bundle carried with every buffered entry.
package decode_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_SLT    = 4'd8;
    localparam logic [3:0] ALU_SLTU   = 4'd9;
    localparam logic [3:0] ALU_MUL    = 4'd10;
    localparam logic [3:0] ALU_MULH   = 4'd11;
    localparam logic [3:0] ALU_MULHSU = 4'd12;
    localparam logic [3:0] ALU_MULHU  = 4'd13;

    localparam logic [1:0] SRC_RS     = 2'b00;
    localparam logic [1:0] SRC_RS_IMM = 2'b10;
    localparam logic [1:0] SRC_PC_IMM = 2'b11;

    localparam logic [1:0] WB_IMM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_MEM = 2'b11;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       reg_write;
        logic [1:0] alu_src;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    // funct3 to ALU code for the base integer ops; alt picks arithmetic right shift.
    function automatic logic [3:0] base_alu_op(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I decode: register fields, immediate generation and control
// bundle, with illegal encodings collapsed to a harmless ADD bundle flagged illegal.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit SUPPORT_M = 1'b0
) (
    input  logic [31:0]     instr,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [XLEN-1:0] imm,
    output ctrl_t           ctrl
);

    // On RV64 funct7[0] is shamt[5], so it is not part of the shift legality check.
    localparam logic [6:0] SHIFT_MASK = (XLEN == 64) ? 7'b1111110 : 7'b1111111;

    logic [6:0]  opcode_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm32_s;
    ctrl_t       dec_s;
    logic        bad_s;

    assign opcode_s = instr[6:0];
    assign funct7_s = instr[31:25];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign imm      = {{(XLEN-31){imm32_s[31]}}, imm32_s[30:0]};

    // Opcode decode: control fields, 32-bit immediate and illegal detection.
    always_comb begin
        dec_s   = '0;
        imm32_s = 32'd0;
        bad_s   = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                dec_s.alu_src    = SRC_RS;
                dec_s.mem_to_reg = WB_ALU;
                dec_s.reg_write  = 1'b1;
                case (funct7_s)
                    F7_BASE: dec_s.alu_op = base_alu_op(instr[14:12], 1'b0);
                    F7_ALT: begin
                        case (instr[14:12])
                            3'b000:  dec_s.alu_op = ALU_SUB;
                            3'b101:  dec_s.alu_op = ALU_SRA;
                            default: bad_s = 1'b1;
                        endcase
                    end
                    F7_MULDIV: begin
                        if (SUPPORT_M) begin
                            case (instr[14:12])
                                3'b000:  dec_s.alu_op = ALU_MUL;
                                3'b001:  dec_s.alu_op = ALU_MULH;
                                3'b010:  dec_s.alu_op = ALU_MULHSU;
                                3'b011:  dec_s.alu_op = ALU_MULHU;
                                default: bad_s = 1'b1;
                            endcase
                        end else begin
                            bad_s = 1'b1;
                        end
                    end
                    default: bad_s = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                imm32_s          = {{20{instr[31]}}, instr[31:20]};
                dec_s.alu_op     = base_alu_op(instr[14:12], instr[30]);
                dec_s.alu_src    = SRC_RS_IMM;
                dec_s.mem_to_reg = WB_ALU;
                dec_s.reg_write  = 1'b1;
                if (instr[14:12] == 3'b001) begin
                    bad_s = (funct7_s & SHIFT_MASK) != 7'd0;
                end else if (instr[14:12] == 3'b101) begin
                    bad_s = (funct7_s & SHIFT_MASK & ~F7_ALT) != 7'd0;
                end else begin
                    bad_s = 1'b0;
                end
            end
            OPC_LOAD: begin
                imm32_s          = {{20{instr[31]}}, instr[31:20]};
                dec_s.alu_src    = SRC_RS_IMM;
                dec_s.mem_read   = 1'b1;
                dec_s.mem_to_reg = WB_MEM;
                dec_s.reg_write  = 1'b1;
            end
            OPC_STORE: begin
                imm32_s         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_s.alu_src   = SRC_RS_IMM;
                dec_s.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                imm32_s      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                dec_s.alu_op = ALU_SUB;
                dec_s.branch = 1'b1;
            end
            OPC_LUI: begin
                imm32_s         = {instr[31:12], 12'd0};
                dec_s.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm32_s          = {instr[31:12], 12'd0};
                dec_s.alu_src    = SRC_PC_IMM;
                dec_s.mem_to_reg = WB_ALU;
                dec_s.reg_write  = 1'b1;
            end
            OPC_JAL: begin
                imm32_s          = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                dec_s.alu_src    = SRC_PC_IMM;
                dec_s.mem_to_reg = WB_PC4;
                dec_s.jump       = 1'b1;
                dec_s.reg_write  = 1'b1;
            end
            OPC_JALR: begin
                imm32_s          = {{20{instr[31]}}, instr[31:20]};
                dec_s.alu_src    = SRC_RS_IMM;
                dec_s.mem_to_reg = WB_PC4;
                dec_s.jump       = 1'b1;
                dec_s.reg_write  = 1'b1;
            end
            default: bad_s = 1'b1;
        endcase
    end

    // Illegal entries carry no side effects downstream.
    always_comb begin
        if (bad_s || (instr[1:0] != 2'b11)) begin
            ctrl         = '0;
            ctrl.alu_op  = ALU_ADD;
            ctrl.illegal = 1'b1;
        end else begin
            ctrl = dec_s;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Elastic decode stage: combinational decode feeding a 2-entry (head + skid) buffer
// with flush, registered handshake and a count of entries taken downstream.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit SUPPORT_M = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic [XLEN-1:0]  out_imm,
    output logic [3:0]       out_alu_op,
    output logic             out_reg_write,
    output logic [1:0]       out_alu_src,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic [1:0]       out_mem_to_reg,
    output logic             out_branch,
    output logic             out_jump,
    output logic             out_illegal,
    output logic [CNT_W-1:0] decoded_count
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        ctrl_t           ctrl;
    } entry_t;

    entry_t            dec_entry_s;
    entry_t            head_r;
    entry_t            skid_r;
    logic [1:0]        count_r;
    logic              out_valid_r;
    logic              in_ready_r;
    logic [CNT_W-1:0]  decoded_count_r;
    logic              push_s;
    logic              pop_s;

    decode_comb #(
        .XLEN      (XLEN),
        .SUPPORT_M (SUPPORT_M)
    ) u_decode_comb (
        .instr  (in_instr),
        .rs1    (dec_entry_s.rs1),
        .rs2    (dec_entry_s.rs2),
        .rd     (dec_entry_s.rd),
        .funct3 (dec_entry_s.funct3),
        .imm    (dec_entry_s.imm),
        .ctrl   (dec_entry_s.ctrl)
    );

    assign dec_entry_s.pc = in_pc;
    assign push_s         = in_valid && in_ready_r;
    assign pop_s          = out_valid_r && out_ready;

    // Head/skid occupancy; flush only drops valid state, reset also zeroes the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r      <= '0;
            skid_r      <= '0;
            count_r     <= 2'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (flush) begin
            count_r     <= 2'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r      <= dec_entry_s;
                        count_r     <= 2'd1;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else begin
                        skid_r      <= dec_entry_s;
                        count_r     <= 2'd2;
                        in_ready_r  <= 1'b0;
                    end
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        head_r      <= skid_r;
                        count_r     <= 2'd1;
                        in_ready_r  <= 1'b1;
                    end else begin
                        count_r     <= 2'd0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                // Only reachable with one entry: the head is replaced in place.
                2'b11:   head_r <= dec_entry_s;
                default: head_r <= head_r;
            endcase
        end
    end

    // Entries taken downstream; a head popped during flush is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            decoded_count_r <= '0;
        end else if (pop_s && !flush) begin
            decoded_count_r <= decoded_count_r + 1'b1;
        end else begin
            decoded_count_r <= decoded_count_r;
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = out_valid_r;
    assign out_pc         = head_r.pc;
    assign out_rs1        = head_r.rs1;
    assign out_rs2        = head_r.rs2;
    assign out_rd         = head_r.rd;
    assign out_funct3     = head_r.funct3;
    assign out_imm        = head_r.imm;
    assign out_alu_op     = head_r.ctrl.alu_op;
    assign out_reg_write  = head_r.ctrl.reg_write;
    assign out_alu_src    = head_r.ctrl.alu_src;
    assign out_mem_read   = head_r.ctrl.mem_read;
    assign out_mem_write  = head_r.ctrl.mem_write;
    assign out_mem_to_reg = head_r.ctrl.mem_to_reg;
    assign out_branch     = head_r.ctrl.branch;
    assign out_jump       = head_r.ctrl.jump;
    assign out_illegal    = head_r.ctrl.illegal;
    assign decoded_count  = decoded_count_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: base instance without M, a second with M and a
// 2-bit counter to exercise MUL decode and counter wrap.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic [3:0]  out_alu_op;
    logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal;
    logic [1:0]  out_alu_src, out_mem_to_reg;
    logic [15:0] decoded_count;

    logic        m_in_valid;
    logic [31:0] m_in_instr;
    logic        m_in_ready, m_out_valid;
    logic [31:0] m_out_pc, m_out_imm;
    logic [4:0]  m_out_rs1, m_out_rs2, m_out_rd;
    logic [2:0]  m_out_funct3;
    logic [3:0]  m_out_alu_op;
    logic        m_out_reg_write, m_out_mem_read, m_out_mem_write, m_out_branch, m_out_jump, m_out_illegal;
    logic [1:0]  m_out_alu_src, m_out_mem_to_reg;
    logic [1:0]  m_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .SUPPORT_M(1'b0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_imm(out_imm), .out_alu_op(out_alu_op),
        .out_reg_write(out_reg_write), .out_alu_src(out_alu_src), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg), .out_branch(out_branch),
        .out_jump(out_jump), .out_illegal(out_illegal), .decoded_count(decoded_count)
    );

    decode_stage #(.XLEN(32), .SUPPORT_M(1'b1), .CNT_W(2)) dut_m (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_instr(m_in_instr), .in_pc(32'h0000_1000), .out_valid(m_out_valid), .out_ready(1'b1),
        .out_pc(m_out_pc), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_rd(m_out_rd),
        .out_funct3(m_out_funct3), .out_imm(m_out_imm), .out_alu_op(m_out_alu_op),
        .out_reg_write(m_out_reg_write), .out_alu_src(m_out_alu_src), .out_mem_read(m_out_mem_read),
        .out_mem_write(m_out_mem_write), .out_mem_to_reg(m_out_mem_to_reg), .out_branch(m_out_branch),
        .out_jump(m_out_jump), .out_illegal(m_out_illegal), .decoded_count(m_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 32'd0; m_in_valid = 1'b0; m_in_instr = 32'd0;
        step(); step();
        rst = 1'b0;
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_imm", out_imm, 32'd0);
        check("rst_cnt", decoded_count, 16'd0);

        // add x0,x1,x2 with downstream ready
        in_valid = 1'b1; in_instr = 32'h0020_8033; in_pc = 32'h0000_0100; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("add_valid", out_valid, 1'b1);
        check("add_aluop", out_alu_op, 4'd0);
        check("add_src", out_alu_src, 2'b00);
        check("add_wb", out_mem_to_reg, 2'b01);
        check("add_rw", out_reg_write, 1'b1);
        check("add_rs", {out_rs1, out_rs2, out_rd}, {5'd1, 5'd2, 5'd0});
        check("add_pc", out_pc, 32'h0000_0100);
        step();
        check("add_popped", out_valid, 1'b0);
        check("add_cnt", decoded_count, 16'd1);

        // Backpressure: lw, sw accepted, beq stalls until the head drains
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0020_2083; in_pc = 32'h0000_0200;
        step();
        check("bp_ready1", in_ready, 1'b1);
        in_instr = 32'h0020_2023; in_pc = 32'h0000_0204;
        step();
        check("bp_full", in_ready, 1'b0);
        check("bp_lw_pc", out_pc, 32'h0000_0200);
        check("bp_lw_rd", out_mem_read, 1'b1);
        in_instr = 32'h0020_8063; in_pc = 32'h0000_0208;
        step();
        check("bp_stall", in_ready, 1'b0);
        check("bp_hold_pc", out_pc, 32'h0000_0200);
        check("bp_hold_imm", out_imm, 32'd2);
        check("bp_hold_wb", out_mem_to_reg, 2'b11);
        out_ready = 1'b1;
        step();
        check("bp_sw_pc", out_pc, 32'h0000_0204);
        check("bp_sw_mw", out_mem_write, 1'b1);
        check("bp_sw_rw", out_reg_write, 1'b0);
        check("bp_ready2", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        check("bp_beq_pc", out_pc, 32'h0000_0208);
        check("bp_beq_br", out_branch, 1'b1);
        check("bp_beq_op", out_alu_op, 4'd1);
        step();
        check("bp_empty", out_valid, 1'b0);
        check("bp_cnt", decoded_count, 16'd4);

        // Immediates streamed back to back
        in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 32'h0000_0300;
        step();
        check("addi_imm", out_imm, 32'hFFFF_FFFF);
        check("addi_src", out_alu_src, 2'b10);
        in_instr = 32'h1234_50B7; in_pc = 32'h0000_0304;
        step();
        check("lui_imm", out_imm, 32'h1234_5000);
        check("lui_wb", out_mem_to_reg, 2'b00);
        check("lui_rw", out_reg_write, 1'b1);
        in_instr = 32'h0040_00EF; in_pc = 32'h0000_0308;
        step();
        in_valid = 1'b0;
        check("jal_imm", out_imm, 32'd4);
        check("jal_jump", out_jump, 1'b1);
        check("jal_wb", out_mem_to_reg, 2'b10);
        check("jal_src", out_alu_src, 2'b11);
        step();
        check("imm_cnt", decoded_count, 16'd7);

        // mul on both instances; srai and a bad SUB-class funct3 as extra vectors
        in_valid = 1'b1; in_instr = 32'h0220_8033;
        m_in_valid = 1'b1; m_in_instr = 32'h0220_8033;
        step();
        check("mul_ill", out_illegal, 1'b1);
        check("mul_rw", out_reg_write, 1'b0);
        check("mul_op", out_alu_op, 4'd0);
        check("m_mul_op", m_out_alu_op, 4'd10);
        check("m_mul_ill", m_out_illegal, 1'b0);
        in_instr = 32'h4010_D093;
        m_in_instr = 32'h0220_B033;
        step();
        check("srai_op", out_alu_op, 4'd7);
        check("srai_ill", out_illegal, 1'b0);
        check("m_mulhu_op", m_out_alu_op, 4'd13);
        in_instr = 32'h4020_9033;
        step();
        check("badsub_ill", out_illegal, 1'b1);
        in_instr = 32'h0020_8032;
        step();
        check("lowbits_ill", out_illegal, 1'b1);
        check("lowbits_rw", out_reg_write, 1'b0);
        step();
        in_valid = 1'b0;
        m_in_valid = 1'b0;
        step();
        // 12 pops on dut so far; 5 pops on dut_m wrap a 2-bit counter to 1
        check("ill_cnt", decoded_count, 16'd12);
        check("m_wrap", m_count, 2'd1);

        // Flush with both slots full, plus push and pop requests
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF0_0093;
        step(); step();
        check("fl_full", in_ready, 1'b0);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", out_valid, 1'b0);
        check("fl_ready", in_ready, 1'b1);
        check("fl_cnt", decoded_count, 16'd12);
        step();
        check("fl_cnt2", decoded_count, 16'd12);

        // Reset mid-stream with one entry held
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h1234_50B7; in_pc = 32'h0000_0400;
        step();
        in_valid = 1'b0;
        check("mr_held", out_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_valid", out_valid, 1'b0);
        check("mr_ready", in_ready, 1'b1);
        check("mr_cnt", decoded_count, 16'd0);
        check("mr_fields", {out_pc, out_imm}, 64'd0);
        check("mr_ctrl", {out_alu_op, out_reg_write, out_alu_src, out_mem_to_reg, out_rd}, 14'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
